count_stop_monitor: RTL and testbench

//  Receive side of the free-running 0..TERMINAL count stream driven by the loop counter producer.

---
 rtl/count_stop_monitor.sv | 199 +++++++++++++++++++
 tb/tb_count_stop_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/count_stop_monitor.sv
// ============================================================================
// Module   : count_stop_monitor
// Purpose  : Receive-side checker for a 0..TERMINAL count stream. Tracks the
//            expected next value, pulses stop when TERMINAL arrives in
//            sequence, latches sequence errors and keeps a saturating tally.
// Options  : define COUNT_MON_TIMEOUT_EN to build the inter-sample watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_stop_monitor #(
  parameter int W        = 4,
  parameter int TERMINAL = 15,
  parameter int TIMEOUT  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cnt_valid,
  input  logic [W-1:0] cnt_in,
  input  logic         clear,
  output logic         stop,
  output logic         done,
  output logic         seq_err,
  output logic         timeout,
  output logic [W:0]   samples,
  output logic [7:0]   err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [W-1:0] C_TERM = W'(TERMINAL);

  // Parameter legality is checked once at elaboration.
  if (TERMINAL < 1 || TERMINAL > (2**W) - 1) begin : g_bad_terminal
    $error("count_stop_monitor: TERMINAL out of range 1..2**W-1");
  end

  state_t       state_q,    state_d;
  logic [W-1:0] expected_q, expected_d;
  logic [W:0]   samples_q,  samples_d;
  logic [7:0]   err_cnt_q,  err_cnt_d;
  logic         stop_q,     stop_d;
  logic         done_q,     done_d;
  logic         seq_err_q,  seq_err_d;

  // Saturating increment of the error tally, shared by both error paths.
  logic [7:0]   err_inc;
  assign err_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

`ifdef COUNT_MON_TIMEOUT_EN
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("count_stop_monitor: TIMEOUT must be >= 2");
  end

  localparam int           WD_W     = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`else
  // Without the watchdog TIMEOUT has no effect; flag a value that would
  // otherwise be illegal so a later enable does not surprise anyone.
  if (TIMEOUT < 2) begin : g_timeout_unused
    $info("count_stop_monitor: TIMEOUT ignored, watchdog not built");
  end
`endif

  // Next-state and next-output decode; clear beats cnt_valid everywhere.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    samples_d  = samples_q;
    err_cnt_d  = err_cnt_q;
    stop_d     = 1'b0;
    done_d     = done_q;
    seq_err_d  = seq_err_q;
`ifdef COUNT_MON_TIMEOUT_EN
    wd_d       = wd_q;
    timeout_d  = timeout_q;
`endif

    if (clear) begin
      state_d    = S_IDLE;
      expected_d = '0;
      samples_d  = '0;
      done_d     = 1'b0;
      seq_err_d  = 1'b0;
`ifdef COUNT_MON_TIMEOUT_EN
      wd_d       = '0;
      timeout_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cnt_valid) begin
            if (cnt_in == '0) begin
              state_d    = S_TRACK;
              expected_d = {{(W-1){1'b0}}, 1'b1};
              samples_d  = {{W{1'b0}}, 1'b1};
`ifdef COUNT_MON_TIMEOUT_EN
              wd_d       = '0;
`endif
            end else begin
              state_d   = S_ERROR;
              seq_err_d = 1'b1;
              err_cnt_d = err_inc;
            end
          end
        end

        S_TRACK: begin
          if (cnt_valid) begin
`ifdef COUNT_MON_TIMEOUT_EN
            wd_d = '0;
`endif
            if (cnt_in != expected_q) begin
              state_d   = S_ERROR;
              seq_err_d = 1'b1;
              err_cnt_d = err_inc;
            end else if (cnt_in == C_TERM) begin
              // expected stops at TERMINAL, so it never needs to wrap.
              state_d   = S_DONE;
              samples_d = samples_q + 1'b1;
              stop_d    = 1'b1;
              done_d    = 1'b1;
            end else begin
              samples_d  = samples_q + 1'b1;
              expected_d = expected_q + 1'b1;
            end
          end
`ifdef COUNT_MON_TIMEOUT_EN
          else if (wd_q == C_WD_LAST) begin
            state_d   = S_ERROR;
            timeout_d = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
`endif
        end

        // DONE and ERROR ignore the stream until clear or reset.
        default: begin
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      expected_q <= '0;
      samples_q  <= '0;
      err_cnt_q  <= '0;
      stop_q     <= 1'b0;
      done_q     <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      samples_q  <= samples_d;
      err_cnt_q  <= err_cnt_d;
      stop_q     <= stop_d;
      done_q     <= done_d;
      seq_err_q  <= seq_err_d;
    end
  end

`ifdef COUNT_MON_TIMEOUT_EN
  // Watchdog counter and its sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign stop      = stop_q;
  assign done      = done_q;
  assign seq_err   = seq_err_q;
  assign samples   = samples_q;
  assign err_count = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_count_stop_monitor.sv
`default_nettype none

module tb_count_stop_monitor;

  localparam int W = 4;

`ifdef COUNT_MON_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cnt_valid = 1'b0;
  logic [W-1:0] cnt_in = '0;
  logic         clear = 1'b0;
  logic         stop, done, seq_err, timeout;
  logic [W:0]   samples;
  logic [7:0]   err_count;

  count_stop_monitor #(.W(W), .TERMINAL(15), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_valid (cnt_valid),
    .cnt_in    (cnt_in),
    .clear     (clear),
    .stop      (stop),
    .done      (done),
    .seq_err   (seq_err),
    .timeout   (timeout),
    .samples   (samples),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    name;
    bit       chk;
    bit       stop;
    bit       done;
    bit       seq_err;
    bit       timeout;
    int       samples;
    int       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_err = 0;

  function automatic exp_t mk(string n, bit st, bit dn, bit se, bit to, int smp, int er);
    exp_t e;
    e.name = n; e.chk = 1'b1; e.stop = st; e.done = dn; e.seq_err = se;
    e.timeout = to; e.samples = smp; e.err = er;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    n_cmp++;
    if (stop !== e.stop || done !== e.done || seq_err !== e.seq_err ||
        timeout !== e.timeout || samples !== (W+1)'(e.samples) ||
        err_count !== 8'(e.err)) begin
      n_err++;
      $display("FAIL %s: got stop=%b done=%b seq=%b to=%b smp=%0d err=%0d, want stop=%b done=%b seq=%b to=%b smp=%0d err=%0d",
               e.name, stop, done, seq_err, timeout, samples, err_count,
               e.stop, e.done, e.seq_err, e.timeout, e.samples, e.err);
    end
  endtask

  // Monitor: one expectation per clock edge, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) compare(e);
    end
  end

  // Drive one cycle of inputs and queue what the outputs must be after it.
  task automatic step(input bit v, input int c, input bit clr, input exp_t e);
    cnt_valid = v;
    cnt_in    = W'(c);
    clear     = clr;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    cnt_valid = 1'b0;
    clear     = 1'b0;
  endtask

  function automatic int bump(input int er);
    return (er < 255) ? er + 1 : er;
  endfunction

  // Async reset pulse between edges, checked immediately.
  task automatic pulse_reset(input string n);
    @(negedge clk);
    #1;
    cnt_valid = 1'b0;
    clear     = 1'b0;
    rst       = 1'b1;
    #1;
    exp_err = 0;
    compare(mk(n, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "bench timeout");
  end

  initial begin
    pulse_reset("reset_state");
    step(0, 0, 0, mk("idle_after_reset", 0, 0, 0, 0, 0, 0));

    // 1: 0..15 with a gap after each sample.
    for (int k = 0; k < 16; k++) begin
      step(1, k, 0, mk("t1_sample", k == 15, k == 15, 0, 0, k + 1, 0));
      step(0, 0, 0, mk("t1_gap", 0, k == 15, 0, 0, k + 1, 0));
    end
    step(1, 0, 0, mk("t1_done_ignores_valid", 0, 1, 0, 0, 16, 0));

    // 2: 0,1,2,4 -> sequence error, then clear.
    step(0, 0, 1, mk("t2_clear", 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      step(1, k, 0, mk("t2_sample", 0, 0, 0, 0, k + 1, 0));
    exp_err = bump(exp_err);
    step(1, 4, 0, mk("t2_skip_error", 0, 0, 1, 0, 3, exp_err));
    step(1, 5, 0, mk("t2_error_holds", 0, 0, 1, 0, 3, exp_err));
    step(0, 0, 1, mk("t2_clear_keeps_err", 0, 0, 0, 0, 0, exp_err));

    // 3: bad first sample, repeated until the tally saturates.
    pulse_reset("t3_reset");
    for (int i = 0; i < 300; i++) begin
      exp_err = bump(exp_err);
      step(1, 3, 0, mk("t3_bad_first", 0, 0, 1, 0, 0, exp_err));
      step(0, 0, 1, mk("t3_clear", 0, 0, 0, 0, 0, exp_err));
    end
    step(0, 0, 0, mk("t3_saturated", 0, 0, 0, 0, 0, 255));

    // 4: back-to-back run into DONE, then clear with a simultaneous valid(0).
    for (int k = 0; k < 16; k++)
      step(1, k, 0, mk("t4_b2b", k == 15, k == 15, 0, 0, k + 1, 255));
    step(1, 0, 1, mk("t4_clear_beats_valid", 0, 0, 0, 0, 0, 255));
    step(1, 0, 0, mk("t4_restart", 0, 0, 0, 0, 1, 255));

    // 5: abort mid-run with reset, then a full clean run.
    step(0, 0, 1, mk("t5_clear", 0, 0, 0, 0, 0, 255));
    for (int k = 0; k < 8; k++)
      step(1, k, 0, mk("t5_pre", 0, 0, 0, 0, k + 1, 255));
    pulse_reset("t5_async_reset");
    step(1, 8, 0, mk("t5_after_reset_idle_err", 0, 0, 1, 0, 0, 1));
    step(0, 0, 1, mk("t5_clear2", 0, 0, 0, 0, 0, 1));
    exp_err = 1;
    for (int k = 0; k < 16; k++)
      step(1, k, 0, mk("t5_run", k == 15, k == 15, 0, 0, k + 1, exp_err));
    step(0, 0, 0, mk("t5_stop_one_cycle", 0, 1, 0, 0, 16, exp_err));

    // 6: watchdog.
    step(0, 0, 1, mk("t6_clear", 0, 0, 0, 0, 0, exp_err));
    step(1, 0, 0, mk("t6_first", 0, 0, 0, 0, 1, exp_err));
    if (WD_ON) begin
      for (int k = 0; k < 7; k++)
        step(0, 0, 0, mk("t6_idle7", 0, 0, 0, 0, 1, exp_err));
      step(1, 1, 0, mk("t6_valid_in_time", 0, 0, 0, 0, 2, exp_err));
      for (int k = 0; k < 7; k++)
        step(0, 0, 0, mk("t6_idle_pre", 0, 0, 0, 0, 2, exp_err));
      step(0, 0, 0, mk("t6_timeout", 0, 0, 0, 1, 2, exp_err));
      step(1, 2, 0, mk("t6_timeout_holds", 0, 0, 0, 1, 2, exp_err));
      step(0, 0, 1, mk("t6_clear_timeout", 0, 0, 0, 0, 0, exp_err));
    end else begin
      for (int k = 0; k < 20; k++)
        step(0, 0, 0, mk("t6_no_watchdog", 0, 0, 0, 0, 1, exp_err));
      step(1, 1, 0, mk("t6_still_tracking", 0, 0, 0, 0, 2, exp_err));
    end

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
